// File: rtl/uart_pkg.sv
// Shared types for the UART receive path.
// Parity modes, receiver FSM states and a majority-vote helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO; head entry is read straight from storage.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_ok = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr_ok = push && (!full || pop);
    assign rdata = empty ? '0 : mem[rptr];

    always_ff @(posedge CLK) begin
        if (wr_ok) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count <= count + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting feeding a FWFT receive FIFO.
// Frames with framing/parity errors are stored along with their flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int      CLKS_PER_BIT = 868,
    parameter int      DATA_BITS    = 8,
    parameter parity_t PARITY       = PAR_NONE,
    parameter int      STOP_BITS    = 1,
    parameter int      FIFO_DEPTH   = 16
) (
    input  logic                            CLK,
    input  logic                            RST_N,
    input  logic                            IN,
    output logic [DATA_BITS-1:0]            data,
    output logic                            valid,
    input  logic                            ready,
    output logic                            frame_err,
    output logic                            parity_err,
    output logic                            overrun,
    input  logic                            clr_overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int FW = DATA_BITS + 2;

    localparam logic [CW-1:0] C_A   = CW'(H - 1);
    localparam logic [CW-1:0] C_B   = CW'(H);
    localparam logic [CW-1:0] C_C   = CW'(H + 1);
    localparam logic [CW-1:0] C_END = CW'(CLKS_PER_BIT - 1);

    logic [1:0]           sync_q;
    logic                 rx;
    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           bidx, bidx_n;
    logic [1:0]           smp, smp_n;
    logic                 bit_q, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 ferr, ferr_n;
    logic                 perr, perr_n;
    logic                 maj;
    logic                 dec;
    logic                 bend;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [FW-1:0]        wdata;
    logic [FW-1:0]        rdata;

    // Synchroniser idles high so reset release never looks like a start bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], IN};
        end
    end

    assign rx = sync_q[1];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bidx  <= '0;
            smp   <= '0;
            bit_q <= 1'b0;
            shift <= '0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bidx  <= bidx_n;
            smp   <= smp_n;
            bit_q <= bit_n;
            shift <= shift_n;
            ferr  <= ferr_n;
            perr  <= perr_n;
        end
    end

    assign maj  = maj3(smp[1], smp[0], rx);
    assign dec  = (cnt == C_C);
    assign bend = (cnt == C_END);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bidx_n  = bidx;
        smp_n   = smp;
        bit_n   = bit_q;
        shift_n = shift;
        ferr_n  = ferr;
        perr_n  = perr;
        push    = 1'b0;
        if (cnt == C_A) smp_n[1] = rx;
        if (cnt == C_B) smp_n[0] = rx;
        if (dec)        bit_n    = maj;
        unique case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (!rx) begin
                    state_n = ST_START;
                    ferr_n  = 1'b0;
                    perr_n  = 1'b0;
                end
            end
            ST_START: begin
                if (dec && maj) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (bend) begin
                    state_n = ST_DATA;
                    cnt_n   = '0;
                    bidx_n  = '0;
                end
            end
            ST_DATA: begin
                if (bend) begin
                    cnt_n   = '0;
                    shift_n = {bit_q, shift[DATA_BITS-1:1]};
                    if (bidx == 3'(DATA_BITS - 1)) begin
                        bidx_n  = '0;
                        state_n = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bidx_n = bidx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bend) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                    perr_n  = (^shift) ^ bit_q ^ (PARITY == PAR_ODD);
                end
            end
            ST_STOP: begin
                // Leave on the last stop decision so a tight next start is caught.
                if (dec && bidx == 3'(STOP_BITS - 1)) begin
                    push    = 1'b1;
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (bend) begin
                    cnt_n  = '0;
                    bidx_n = bidx + 1'b1;
                    ferr_n = ferr | ~bit_q;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign wdata = {perr, ferr | ~maj, shift};
    assign pop   = valid && ready;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign valid      = !empty;
    assign data       = rdata[DATA_BITS-1:0];
    assign frame_err  = rdata[DATA_BITS];
    assign parity_err = rdata[FW-1] & (PARITY != PAR_NONE);

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun <= 1'b0;
        end else if (push && full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: 8N1 and 8E1 receivers, 16 clocks per bit, 4-entry FIFO.
// Each scenario task drives the serial line and checks outputs inline.
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int QW    = $clog2(DEPTH + 1);

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          in_n = 1'b1;
    logic          in_p = 1'b1;
    logic          ready_n = 1'b0;
    logic          ready_p = 1'b0;
    logic          clr_n = 1'b0;
    logic          clr_p = 1'b0;
    logic [7:0]    data_n, data_p;
    logic          valid_n, valid_p;
    logic          ferr_n, ferr_p;
    logic          perr_n, perr_p;
    logic          ovr_n, ovr_p;
    logic [QW-1:0] count_n, count_p;

    int checks = 0;
    int fails  = 0;

    always #5 CLK = ~CLK;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (PAR_NONE),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IN          (in_n),
        .data        (data_n),
        .valid       (valid_n),
        .ready       (ready_n),
        .frame_err   (ferr_n),
        .parity_err  (perr_n),
        .overrun     (ovr_n),
        .clr_overrun (clr_n),
        .count       (count_n)
    );

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .PARITY       (PAR_EVEN),
        .STOP_BITS    (1),
        .FIFO_DEPTH   (DEPTH)
    ) dut_p (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .IN          (in_p),
        .data        (data_p),
        .valid       (valid_p),
        .ready       (ready_p),
        .frame_err   (ferr_p),
        .parity_err  (perr_p),
        .overrun     (ovr_p),
        .clr_overrun (clr_p),
        .count       (count_p)
    );

    task automatic drive_bit(input bit p, input logic b);
        @(negedge CLK);
        if (p) in_p = b;
        else   in_n = b;
        repeat (CPB - 1) @(negedge CLK);
    endtask

    task automatic send(input bit p, input logic [7:0] d,
                        input int pbit, input logic stopv);
        drive_bit(p, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(p, d[i]);
        if (pbit >= 0) drive_bit(p, pbit[0]);
        drive_bit(p, stopv);
    endtask

    task automatic watch(input bit p, input int cyc, output int pulses,
                         output logic [7:0] d, output logic fe,
                         output logic pe);
        pulses = 0;
        d  = '0;
        fe = 1'b0;
        pe = 1'b0;
        repeat (cyc) begin
            @(negedge CLK);
            if (p ? valid_p : valid_n) begin
                if (pulses == 0) begin
                    d  = p ? data_p : data_n;
                    fe = p ? ferr_p : ferr_n;
                    pe = p ? perr_p : perr_n;
                end
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (5) @(negedge CLK);
        checks++;
        if (valid_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %b want 0", valid_n);
        end
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (count_n !== 3'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d want 0", count_n);
        end
        checks++;
        if (ovr_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_overrun: got %b want 0", ovr_n);
        end
        checks++;
        if (data_n !== 8'h00 || ferr_n !== 1'b0 || perr_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_outs: got %h/%b/%b want 00/0/0",
                     data_n, ferr_n, perr_n);
        end
        checks++;
        if (valid_p !== 1'b0 || count_p !== 3'd0) begin
            fails++;
            $display("FAIL reset_par: got v=%b c=%0d want 0/0",
                     valid_p, count_p);
        end
    endtask

    task automatic test_basic();
        int         pulses;
        logic [7:0] d;
        logic       fe, pe;
        ready_n = 1'b1;
        fork
            send(1'b0, 8'hA5, -1, 1'b1);
            watch(1'b0, 200, pulses, d, fe, pe);
        join
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL basic_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (d !== 8'hA5) begin
            fails++;
            $display("FAIL basic_data: got %h want a5", d);
        end
        checks++;
        if (fe !== 1'b0 || pe !== 1'b0) begin
            fails++;
            $display("FAIL basic_flags: got fe=%b pe=%b want 0/0", fe, pe);
        end
        checks++;
        if (count_n !== 3'd0) begin
            fails++;
            $display("FAIL basic_count: got %0d want 0", count_n);
        end
        ready_n = 1'b0;
    endtask

    task automatic test_parity();
        int         pulses;
        logic [7:0] d;
        logic       fe, pe;
        ready_p = 1'b1;
        fork
            send(1'b1, 8'h07, 0, 1'b1);
            watch(1'b1, 220, pulses, d, fe, pe);
        join
        checks++;
        if (pulses !== 1 || d !== 8'h07) begin
            fails++;
            $display("FAIL par_bad_data: got n=%0d d=%h want 1/07", pulses, d);
        end
        checks++;
        if (pe !== 1'b1 || fe !== 1'b0) begin
            fails++;
            $display("FAIL par_bad_flag: got pe=%b fe=%b want 1/0", pe, fe);
        end
        fork
            send(1'b1, 8'h07, 1, 1'b1);
            watch(1'b1, 220, pulses, d, fe, pe);
        join
        checks++;
        if (pulses !== 1 || d !== 8'h07) begin
            fails++;
            $display("FAIL par_ok_data: got n=%0d d=%h want 1/07", pulses, d);
        end
        checks++;
        if (pe !== 1'b0) begin
            fails++;
            $display("FAIL par_ok_flag: got pe=%b want 0", pe);
        end
        ready_p = 1'b0;
    endtask

    task automatic test_frame_err();
        ready_n = 1'b0;
        send(1'b0, 8'h3C, -1, 1'b0);
        send(1'b0, 8'h55, -1, 1'b1);
        repeat (4) @(negedge CLK);
        checks++;
        if (count_n !== 3'd2) begin
            fails++;
            $display("FAIL ferr_count: got %0d want 2", count_n);
        end
        checks++;
        if (data_n !== 8'h3C || ferr_n !== 1'b1) begin
            fails++;
            $display("FAIL ferr_head: got %h fe=%b want 3c/1", data_n, ferr_n);
        end
        ready_n = 1'b1;
        @(negedge CLK);
        ready_n = 1'b0;
        checks++;
        if (data_n !== 8'h55 || ferr_n !== 1'b0 || valid_n !== 1'b1) begin
            fails++;
            $display("FAIL ferr_next: got %h fe=%b v=%b want 55/0/1",
                     data_n, ferr_n, valid_n);
        end
        ready_n = 1'b1;
        @(negedge CLK);
        ready_n = 1'b0;
        checks++;
        if (count_n !== 3'd0 || valid_n !== 1'b0) begin
            fails++;
            $display("FAIL ferr_drain: got c=%0d v=%b want 0/0",
                     count_n, valid_n);
        end
    endtask

    task automatic test_glitch();
        int         pulses;
        logic [7:0] d;
        logic       fe, pe;
        @(negedge CLK);
        in_n = 1'b0;
        repeat (4) @(negedge CLK);
        in_n = 1'b1;
        watch(1'b0, 60, pulses, d, fe, pe);
        checks++;
        if (pulses !== 0 || count_n !== 3'd0) begin
            fails++;
            $display("FAIL glitch_push: got n=%0d c=%0d want 0/0",
                     pulses, count_n);
        end
        checks++;
        if (dut.state !== ST_IDLE) begin
            fails++;
            $display("FAIL glitch_state: got %0d want %0d",
                     dut.state, ST_IDLE);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp;
        ready_n = 1'b0;
        for (int i = 1; i <= 5; i++) send(1'b0, 8'(i), -1, 1'b1);
        repeat (4) @(negedge CLK);
        checks++;
        if (count_n !== 3'd4) begin
            fails++;
            $display("FAIL ovr_count: got %0d want 4", count_n);
        end
        checks++;
        if (ovr_n !== 1'b1) begin
            fails++;
            $display("FAIL ovr_flag: got %b want 1", ovr_n);
        end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            checks++;
            if (data_n !== exp || valid_n !== 1'b1) begin
                fails++;
                $display("FAIL ovr_pop%0d: got %h v=%b want %h/1",
                         i, data_n, valid_n, exp);
            end
            ready_n = 1'b1;
            @(negedge CLK);
            ready_n = 1'b0;
        end
        checks++;
        if (count_n !== 3'd0 || ovr_n !== 1'b1) begin
            fails++;
            $display("FAIL ovr_sticky: got c=%0d o=%b want 0/1",
                     count_n, ovr_n);
        end
        clr_n = 1'b1;
        @(negedge CLK);
        clr_n = 1'b0;
        checks++;
        if (ovr_n !== 1'b0) begin
            fails++;
            $display("FAIL ovr_clear: got %b want 0", ovr_n);
        end
    endtask

    task automatic test_reset_mid();
        int         pulses;
        logic [7:0] d;
        logic       fe, pe;
        ready_n = 1'b1;
        @(negedge CLK);
        in_n = 1'b0;
        repeat (CPB) @(negedge CLK);
        in_n = 1'b1;
        repeat (CPB + 8) @(negedge CLK);
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (count_n !== 3'd0 || valid_n !== 1'b0) begin
            fails++;
            $display("FAIL rmid_reset: got c=%0d v=%b want 0/0",
                     count_n, valid_n);
        end
        RST_N = 1'b1;
        fork
            begin
                repeat (60) @(negedge CLK);
                send(1'b0, 8'h12, -1, 1'b1);
            end
            watch(1'b0, 280, pulses, d, fe, pe);
        join
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL rmid_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (d !== 8'h12 || fe !== 1'b0) begin
            fails++;
            $display("FAIL rmid_data: got %h fe=%b want 12/0", d, fe);
        end
        ready_n = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
